// File: rtl/shift_rx_pkg.sv
// Shared definitions for the shift_rx_framer slice.
//   - state_t            : framer FSM states (HUNT, COLLECT)
//   - DIR_LEFT/DIR_RIGHT : values accepted by the SHIFT_DIRECTION parameter
//   - DEFAULT_SYNC_WORD  : default frame-alignment pattern
//   - fifo_count_width() : bits needed for a FIFO occupancy count 0..depth
package shift_rx_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

    // Occupancy must represent both 0 and depth, hence one extra bit.
    function automatic int unsigned fifo_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/shift_rx_fifo.sv
// First-word-fall-through word buffer for shift_rx_framer.
// Ports:
//   clock, aclr      : rising-edge clock, asynchronous active-high reset
//   push, push_data  : write request; accepted when not full, or when a pop
//                      happens on the same edge
//   pop              : remove head word (ignored when empty)
//   pop_data         : head word, forced to 0 while empty
//   full, empty      : occupancy flags
//   count            : number of stored words (0..FIFO_DEPTH)
module shift_rx_fifo
    import shift_rx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                    clock,
    input  logic                                    aclr,
    input  logic                                    push,
    input  logic [WIDTH-1:0]                        push_data,
    input  logic                                    pop,
    output logic [WIDTH-1:0]                        pop_data,
    output logic                                    full,
    output logic                                    empty,
    output logic [fifo_count_width(FIFO_DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = fifo_count_width(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // When full, the slot being freed by the pop is the one written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count is non-zero.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/shift_rx_framer.sv
// Serial receive framer: hunts a bitstream for SYNC_WORD, then assembles the
// following bits into WIDTH-bit words and buffers them for a valid/ready sink.
// Optional feature macro: SHIFT_RX_PARITY_EN (each word is followed by an even
// parity bit; bad words are dropped and flagged on parity_err).
// Ports:
//   clock, aclr  : rising-edge clock, asynchronous active-high reset
//   bit_in       : serial data, sampled only while bit_valid is high
//   bit_valid    : bit qualifier
//   resync       : synchronous return to HUNT (FIFO contents kept)
//   word_out     : FIFO head word
//   word_valid   : FIFO non-empty
//   word_ready   : sink accepts word_out when high together with word_valid
//   locked       : high while in COLLECT
//   overflow     : sticky, a completed word was dropped on a full FIFO
//   parity_err   : one-cycle pulse for a word with bad parity
module shift_rx_framer
    import shift_rx_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD       = WIDTH'(DEFAULT_SYNC_WORD),
    parameter string            SHIFT_DIRECTION = DIR_LEFT,
    parameter int unsigned      FIFO_DEPTH      = 4
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             resync,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             locked,
    output logic             overflow,
    output logic             parity_err
);

    localparam bit          SHIFT_LEFT = (SHIFT_DIRECTION == DIR_LEFT);
    localparam int unsigned CW         = $clog2(WIDTH + 1);
    localparam int unsigned FCW        = fifo_count_width(FIFO_DEPTH);

`ifdef SHIFT_RX_PARITY_EN
    // Assembler keeps the whole word until the parity bit arrives.
    localparam int unsigned   ASM_W    = WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    // The final data bit completes the word combinationally, so only
    // WIDTH-1 earlier bits need storing.
    localparam int unsigned   ASM_W    = WIDTH - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    state_t               state_q, state_d;
    // The window only needs the WIDTH-1 most recent bits; the incoming bit
    // completes the comparison value.
    logic [WIDTH-2:0]     window_q, window_d;
    logic [WIDTH-1:0]     window_next;
    logic [ASM_W-1:0]     asm_q, asm_d;
    logic [WIDTH-1:0]     asm_next;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 sync_hit;

    logic                 push;
    logic [WIDTH-1:0]     push_word;
    logic                 pop;
    logic                 fifo_full, fifo_empty;
    logic [FCW-1:0]       fifo_count;

    // ---------------------------------------------------------------------
    // Shifters
    // ---------------------------------------------------------------------
    if (SHIFT_LEFT) begin : g_left
        assign window_next = {window_q, bit_in};
`ifdef SHIFT_RX_PARITY_EN
        assign asm_next    = {asm_q[WIDTH-2:0], bit_in};
`else
        assign asm_next    = {asm_q, bit_in};
`endif
    end else begin : g_right
        assign window_next = {bit_in, window_q};
`ifdef SHIFT_RX_PARITY_EN
        assign asm_next    = {bit_in, asm_q[WIDTH-1:1]};
`else
        assign asm_next    = {bit_in, asm_q};
`endif
    end

    // Portion of a shifted value that must be retained for later bits.
    function automatic logic [WIDTH-2:0] keep_tail(input logic [WIDTH-1:0] v);
        return SHIFT_LEFT ? v[WIDTH-2:0] : v[WIDTH-1:1];
    endfunction

    assign sync_hit = (window_next == SYNC_WORD);

    // ---------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) state_q <= HUNT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = HUNT;
        end else if (bit_valid) begin
            unique case (state_q)
                HUNT:    if (sync_hit) state_d = COLLECT;
                COLLECT: state_d = COLLECT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == COLLECT);
    end

    // ---------------------------------------------------------------------
    // Window, assembler and bit counter
    // ---------------------------------------------------------------------
`ifdef SHIFT_RX_PARITY_EN
    logic parity_fail;
    logic parity_err_q;
`endif

    always_comb begin
        window_d  = window_q;
        asm_d     = asm_q;
        count_d   = count_q;
        push      = 1'b0;
        push_word = asm_next;
`ifdef SHIFT_RX_PARITY_EN
        parity_fail = 1'b0;
`endif
        if (resync) begin
            window_d = '0;
            asm_d    = '0;
            count_d  = '0;
        end else if (bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    window_d = keep_tail(window_next);
                    count_d  = '0;
                end
                COLLECT: begin
`ifdef SHIFT_RX_PARITY_EN
                    if (count_q == LAST_CNT) begin
                        // bit_in is the parity bit; asm_q holds the word.
                        count_d   = '0;
                        push_word = asm_q;
                        if (^{asm_q, bit_in}) parity_fail = 1'b1;
                        else                  push        = 1'b1;
                    end else begin
                        asm_d   = asm_next;
                        count_d = count_q + CW'(1);
                    end
`else
                    asm_d = keep_tail(asm_next);
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        push    = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Overflow: a completed word arrives at a full FIFO with no pop
    // ---------------------------------------------------------------------
    assign pop = word_ready && !fifo_empty;

    always_comb begin
        overflow_d = overflow_q;
        if (resync)                             overflow_d = 1'b0;
        else if (push && fifo_full && !pop)     overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            window_q   <= '0;
            asm_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            window_q   <= window_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) parity_err_q <= 1'b0;
        else      parity_err_q <= parity_fail;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign overflow = overflow_q;

    // ---------------------------------------------------------------------
    // Word buffer
    // ---------------------------------------------------------------------
    shift_rx_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .aclr      (aclr),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (word_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign word_valid = (fifo_count != '0);

endmodule

// File: tb/tb_shift_rx_framer.sv
`timescale 1ns/1ps
module tb_shift_rx_framer;

`ifdef SHIFT_RX_PARITY_EN
    localparam int G = 9;
`else
    localparam int G = 8;
`endif

    logic       clock = 1'b0;
    logic       aclr = 1'b1;
    logic       bit_in = 1'b0, bit_valid = 1'b0, resync = 1'b0, word_ready = 1'b0;
    logic [7:0] wo_l, wo_r;
    logic       wv_l, wv_r, lk_l, lk_r, ov_l, ov_r, pe_l, pe_r;

    int checks = 0;
    int errors = 0;

    shift_rx_framer #(
        .WIDTH(8), .SYNC_WORD(8'hA5), .SHIFT_DIRECTION("LEFT"), .FIFO_DEPTH(4)
    ) dut_l (
        .clock(clock), .aclr(aclr), .bit_in(bit_in), .bit_valid(bit_valid),
        .resync(resync), .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
        .locked(lk_l), .overflow(ov_l), .parity_err(pe_l)
    );

    shift_rx_framer #(
        .WIDTH(8), .SYNC_WORD(8'hA5), .SHIFT_DIRECTION("RIGHT"), .FIFO_DEPTH(4)
    ) dut_r (
        .clock(clock), .aclr(aclr), .bit_in(bit_in), .bit_valid(bit_valid),
        .resync(resync), .word_out(wo_r), .word_valid(wv_r), .word_ready(word_ready),
        .locked(lk_r), .overflow(ov_r), .parity_err(pe_r)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       bv, bi, rs, rdy;
        logic       lk, wv;
        logic [7:0] wo;
        logic       ov, pe;
    } vec_t;

    vec_t       tbl[$];
    bit         src[$];
    logic [7:0] pop_l[$], pop_r[$], exp_l[$], exp_r[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w, input bit lsb_first);
        for (int k = 0; k < 8; k++) send_bit(lsb_first ? w[k] : w[7-k]);
    endtask

    task automatic send_word(input logic [7:0] w, input bit lsb_first);
        send_byte(w, lsb_first);
`ifdef SHIFT_RX_PARITY_EN
        send_bit(^w);
`endif
    endtask

    task automatic do_reset(input string name);
        aclr = 1'b1;
        bit_valid = 1'b0; resync = 1'b0; word_ready = 1'b0;
        #1;
        check({name, "_L"}, {lk_l, wv_l, wo_l, ov_l, pe_l}, 32'h0);
        check({name, "_R"}, {lk_r, wv_r, wo_r, ov_r, pe_r}, 32'h0);
        aclr = 1'b0;
        step();
    endtask

    function automatic void add(input logic bv, input logic bi, input logic rs,
                                input logic rdy, input logic lk, input logic wv,
                                input logic [7:0] wo);
        vec_t v;
        v.bv = bv; v.bi = bi; v.rs = rs; v.rdy = rdy;
        v.lk = lk; v.wv = wv; v.wo = wo; v.ov = 1'b0; v.pe = 1'b0;
        tbl.push_back(v);
    endfunction

    // Word formed from 8 consecutive stream bits starting at 'start'; bits
    // before the stream start count as 0 (the window starts cleared).
    function automatic logic [7:0] pack(input int start, input bit lsb_first);
        logic [7:0] w;
        for (int k = 0; k < 8; k++) begin
            bit b;
            b = (start + k >= 0) ? src[start + k] : 1'b0;
            if (lsb_first) w[k] = b;
            else           w[7-k] = b;
        end
        return w;
    endfunction

    // Lock after the first bit whose trailing 8 bits spell the sync word,
    // then cut the remainder into groups of G bits.
    function automatic void model(input bit lsb_first);
        int lock_at = -1;
        int pos;
        for (int i = 0; i < src.size() && lock_at < 0; i++)
            if (pack(i - 7, lsb_first) == 8'hA5) lock_at = i;
        if (lock_at < 0) return;
        pos = lock_at + 1;
        while (pos + G <= src.size()) begin
            logic [7:0] w;
            bit ok;
            w  = pack(pos, lsb_first);
            ok = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
            ok = ((^w) == src[pos + 8]);
`endif
            if (ok) begin
                if (lsb_first) exp_r.push_back(w);
                else           exp_l.push_back(w);
            end
            pos += G;
        end
    endfunction

    logic [7:0] a5 = 8'hA5;
    logic [7:0] c3 = 8'h3C;

    initial begin
        // ---------------- table: LEFT sync + one word, pop, resync -------
        for (int i = 0; i < 8; i++) add(1, a5[7-i], 0, 0, i == 7, 0, 8'h00);
        for (int i = 0; i < 8; i++) add(1, c3[7-i], 0, 0, 1, (G == 8) && i == 7, 8'h3C);
`ifdef SHIFT_RX_PARITY_EN
        add(1, 1'b0, 0, 0, 1, 1, 8'h3C);
`endif
        add(0, 0, 0, 1, 1, 0, 8'h00);
        add(1, 1, 1, 0, 0, 0, 8'h00);
        add(0, 0, 0, 0, 0, 0, 8'h00);

        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            bit_valid = tbl[i].bv; bit_in = tbl[i].bi;
            resync = tbl[i].rs; word_ready = tbl[i].rdy;
            step();
            check($sformatf("table[%0d]", i),
                  {lk_l, wv_l, (tbl[i].wv ? wo_l : 8'h00), ov_l, pe_l},
                  {tbl[i].lk, tbl[i].wv, (tbl[i].wv ? tbl[i].wo : 8'h00), tbl[i].ov, tbl[i].pe});
        end
        bit_valid = 0; resync = 0; word_ready = 0;

        // ---------------- gapped input ----------------------------------
        do_reset("reset_gap");
        begin
            logic [7:0] ws [2];
            ws[0] = 8'hA5; ws[1] = 8'h3C;
            for (int w = 0; w < 2; w++)
                for (int k = 0; k < G; k++) begin
                    while ($urandom_range(0, 1) == 1) step();
                    send_bit((k == 8) ? 1'b0 : ws[w][7-k]);
                end
        end
        repeat (3) step();
        check("gap_word", {wv_l, wo_l}, {1'b1, 8'h3C});
        word_ready = 1; step(); word_ready = 0;
        repeat (20) step();
        check("gap_no_extra", {wv_l, ov_l}, 2'b00);

        // ---------------- overflow and drain ----------------------------
        do_reset("reset_ovf");
        send_byte(8'hA5, 0);
        for (int w = 1; w <= 5; w++) send_word(8'(w), 0);
        step();
        check("ovf_hold", {wv_l, wo_l, ov_l}, {1'b1, 8'h01, 1'b1});
        word_ready = 1;
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("drain_%0d", w), {wv_l, wo_l}, {1'b1, 8'(w)});
            step();
        end
        word_ready = 0;
        check("drain_empty", {wv_l, ov_l}, 2'b01);
        resync = 1; step(); resync = 0;
        check("resync_clr_ovf", {ov_l, lk_l}, 2'b00);

        // ---------------- RIGHT direction -------------------------------
        do_reset("reset_right");
        send_byte(8'hA5, 1);
        check("right_locked", lk_r, 1'b1);
        send_word(8'h3C, 1);
        check("right_word", {wv_r, wo_r}, {1'b1, 8'h3C});

        // ---------------- aclr mid-word ---------------------------------
        do_reset("reset_mid");
        send_byte(8'hA5, 0);
        send_word(8'h3C, 0);
        for (int k = 0; k < 4; k++) send_bit(k[0]);
        check("pre_aclr", {lk_l, wv_l}, 2'b11);
        aclr = 1; #1;
        check("aclr_async", {lk_l, wv_l, wo_l, ov_l, pe_l}, 32'h0);
        step(); aclr = 0; step();
        word_ready = 1;
        send_word(8'h3C, 0);
        repeat (4) step();
        check("no_word_before_sync", {lk_l, wv_l}, 2'b00);
        word_ready = 0;
        send_byte(8'hA5, 0);
        send_word(8'h3C, 0);
        check("word_after_sync", {lk_l, wv_l, wo_l}, {2'b11, 8'h3C});

`ifdef SHIFT_RX_PARITY_EN
        // ---------------- parity ----------------------------------------
        do_reset("reset_par");
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0); send_bit(1'b0);
        check("par_good", {wv_l, wo_l, pe_l}, {1'b1, 8'h3C, 1'b0});
        word_ready = 1; step(); word_ready = 0;
        send_byte(8'h3D, 0); send_bit(1'b0);
        check("par_bad_pulse", {pe_l, wv_l}, 2'b10);
        step();
        check("par_pulse_end", {pe_l, wv_l}, 2'b00);
`endif

        // ---------------- randomized vs reference model -----------------
        do_reset("reset_rand");
        for (int i = 0; i < 40; i++) src.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) src.push_back(a5[7-i]);  // A5 reads the same both ways
        for (int i = 0; i < 12 * G; i++) src.push_back(1'($urandom_range(0, 1)));
        begin
            int idx = 0;
            int cyc = 0;
            while (idx < src.size() && cyc < 4000) begin
                bit_valid  = ($urandom_range(0, 2) != 0);
                if (bit_valid) bit_in = src[idx++];
                word_ready = ($urandom_range(0, 3) != 0);
                if (wv_l && word_ready) pop_l.push_back(wo_l);
                if (wv_r && word_ready) pop_r.push_back(wo_r);
                step();
                cyc++;
            end
            check("rand_budget", (idx == src.size()), 1'b1);
            bit_valid = 0; word_ready = 1;
            repeat (20) begin
                if (wv_l) pop_l.push_back(wo_l);
                if (wv_r) pop_r.push_back(wo_r);
                step();
            end
        end
        model(1'b0);
        model(1'b1);
        check("rand_lock_L", lk_l, 1'b1);
        check("rand_lock_R", lk_r, 1'b1);
        check("rand_ovf", {ov_l, ov_r}, 2'b00);
        check("rand_count_L", pop_l.size(), exp_l.size());
        check("rand_count_R", pop_r.size(), exp_r.size());
        for (int i = 0; i < exp_l.size() && i < pop_l.size(); i++)
            check($sformatf("rand_L[%0d]", i), pop_l[i], exp_l[i]);
        for (int i = 0; i < exp_r.size() && i < pop_r.size(); i++)
            check($sformatf("rand_R[%0d]", i), pop_r[i], exp_r[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rx_framer.md
Name: shift_rx_framer

Overview:
- Downstream consumer of the 8-bit shift register's serial output (shiftout).
- Hunts the incoming bitstream for a sync word, then assembles the following bits into parallel words.
- Buffers assembled words in a small FIFO and presents them on a valid/ready interface to the next stage.
- Bit order matches the upstream SHIFT_DIRECTION, so a word loaded upstream is reproduced unchanged here.

Parameters:
- WIDTH, 8, word width in bits (minimum 2).
- SYNC_WORD, 8'hA5, WIDTH-bit frame-alignment pattern.
- SHIFT_DIRECTION, "LEFT", "LEFT" = MSB first; "RIGHT" = LSB first.
- FIFO_DEPTH, 4, word buffer entries (power of 2, minimum 2).

Ports:
- clock  in  1  single clock, rising edge.
- aclr  in  1  asynchronous active-high reset.
- bit_in  in  1  serial data (upstream shiftout).
- bit_valid  in  1  bit_in is sampled only when high (upstream enable).
- resync  in  1  synchronous request to return to HUNT.
- word_out  out  WIDTH  FIFO head word.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts word_out when high together with word_valid.
- locked  out  1  high while in COLLECT.
- overflow  out  1  sticky: a completed word was dropped.
- parity_err  out  1  one-cycle error pulse (see Optional Feature).

Behaviour:
- Reset (aclr high, asynchronous): state HUNT; window, bit count and FIFO cleared; all outputs 0, including word_out.
- Shift rule, used by both the window and the word assembler:
  - LEFT: next = {reg[WIDTH-2:0], bit_in}.
  - RIGHT: next = {bit_in, reg[WIDTH-1:1]}.
- A bit is consumed only on an edge where bit_valid = 1. Cycles with bit_valid = 0 change nothing.
- HUNT state:
  - Each consumed bit shifts into the window.
  - When the next window value equals SYNC_WORD, go to COLLECT on that edge; bit count = 0; locked = 1 from the following cycle.
- COLLECT state:
  - Each consumed bit shifts into the assembler and increments the bit count.
  - On the edge that consumes bit WIDTH, the completed word is pushed to the FIFO and the count returns to 0.
  - word_valid rises the cycle after that edge when the FIFO was empty (latency 1).
  - COLLECT persists until resync or aclr.
- resync (synchronous, priority over bit consumption):
  - State goes to HUNT; window, count, assembler and overflow cleared.
  - FIFO contents retained.
- FIFO behaviour:
  - First-word-fall-through; pop when word_valid && word_ready.
  - Push while full is accepted only if a pop occurs on the same edge. Otherwise the word is dropped and overflow is set, cleared only by resync or aclr.
  - Push and pop together when empty: the word is stored; word_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- word_out holds its value while word_valid && !word_ready.
- Reset mid-word: the partial word is discarded and hunting restarts.

Optional Feature:
- Macro: SHIFT_RX_PARITY_EN.
- Defined:
  - In COLLECT, each word is followed by one even-parity bit; the count runs to WIDTH+1.
  - On the parity bit's edge, if XOR(word, parity) = 1, the word is discarded (not pushed) and parity_err pulses high for one cycle. Otherwise the word is pushed.
  - Latency is measured from the parity bit.
- Undefined: words are exactly WIDTH bits; parity_err is tied to 0.

Decomposition:
- Package shift_rx_pkg contains:
  - state enum {HUNT, COLLECT};
  - direction constants DIR_LEFT / DIR_RIGHT;
  - default SYNC_WORD localparam.
- One sub-module, shift_rx_fifo (parameterised WIDTH/FIFO_DEPTH, push/pop/full/empty/count). Framer FSM and shifters stay in the top.

Test Plan:
- LEFT sync: feed 10100101 then 00111100, bit_valid = 1 → locked = 1 after the 8th bit; word_valid = 1 and word_out = 8'h3C one cycle after the 16th bit.
- Gapped input: same stream with bit_valid randomly 0 on 50% of cycles → identical word_out = 8'h3C; no extra words.
- Overflow: word_ready = 0, lock, then send 5 words 01, 02, 03, 04, 05 → 4 words held (head 8'h01), overflow = 1. Raise word_ready → drains 01..04 in order, then word_valid = 0.
- RIGHT direction: SHIFT_DIRECTION = "RIGHT"; send A5 then 3C, each LSB first → locked, word_out = 8'h3C.
- aclr mid-word: assert after 4 bits of a word → all outputs 0 immediately. After release, bits of 8'h3C alone produce no word until A5 is seen.
- With SHIFT_RX_PARITY_EN defined: 8'h3C + parity 0 → pushed. 8'h3D + parity 0 → parity_err one-cycle pulse, no push.
